// File: rtl/frame_column_loader.sv
// Configuration frame loader for one fabric column: a header, NumRows data words, then a one-hot frame strobe.
// Optional checksum trailer word is enabled by defining FRAME_CRC_EN.
module frame_column_loader #(
  parameter int unsigned NumRows         = 8,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned StrobeCycles    = 2
) (
  input  logic                               UserCLK,
  input  logic                               resetn,
  input  logic [FrameBitsPerRow-1:0]         in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               abort,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic [15:0]                        frames_done,
  output logic                               err_sync,
  output logic                               err_frame,
  output logic                               err_crc
);

  localparam int unsigned RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned CntW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [7:0] SyncByte = 8'hFA;
  localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef FRAME_CRC_EN
    CRC,
`endif
    STROBE,
    GAP
  } state_t;

  state_t          state;
  logic            live;
  logic [RowW-1:0] row;
  logic [CntW-1:0] cnt;
  logic [7:0]      idx;
  logic            accepting;
  logic            xfer;
`ifdef FRAME_CRC_EN
  logic [FrameBitsPerRow-1:0] crc;
`endif

  // Word acceptance: only in word-consuming states, never in reset or during abort
  always_comb begin
    accepting = (state == IDLE) || (state == DATA);
`ifdef FRAME_CRC_EN
    if (state == CRC) accepting = 1'b1;
`endif
  end

  assign in_ready = live && accepting && !abort;
  assign xfer     = in_valid && in_ready;
  assign busy     = (state != IDLE);

`ifndef FRAME_CRC_EN
  assign err_crc = 1'b0;
`endif

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      live        <= 1'b0;
      row         <= '0;
      cnt         <= '0;
      idx         <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      frames_done <= '0;
      err_sync    <= 1'b0;
      err_frame   <= 1'b0;
`ifdef FRAME_CRC_EN
      err_crc     <= 1'b0;
      crc         <= '0;
`endif
    end else begin
      live      <= 1'b1;
      err_sync  <= 1'b0;
      err_frame <= 1'b0;
`ifdef FRAME_CRC_EN
      err_crc   <= 1'b0;
`endif
      if (abort) begin
        state       <= IDLE;
        FrameStrobe <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (xfer) begin
              if (in_data[31:24] != SyncByte) begin
                err_sync <= 1'b1;
              end else if (in_data[7:0] >= 8'(MaxFramesPerCol)) begin
                err_frame <= 1'b1;
              end else begin
                idx   <= in_data[7:0];
                row   <= '0;
                state <= DATA;
`ifdef FRAME_CRC_EN
                crc   <= in_data;
`endif
              end
            end
          end
          DATA: begin
            if (xfer) begin
              for (int r = 0; r < int'(NumRows); r++) begin
                if (row == RowW'(r)) FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
              end
`ifdef FRAME_CRC_EN
              crc <= crc ^ in_data;
`endif
              if (row == RowW'(NumRows - 1)) begin
`ifdef FRAME_CRC_EN
                state <= CRC;
`else
                state       <= STROBE;
                cnt         <= '0;
                FrameStrobe <= StrobeOne << idx;
`endif
              end else begin
                row <= row + RowW'(1);
              end
            end
          end
`ifdef FRAME_CRC_EN
          CRC: begin
            if (xfer) begin
              if (in_data == crc) begin
                state       <= STROBE;
                cnt         <= '0;
                FrameStrobe <= StrobeOne << idx;
              end else begin
                err_crc <= 1'b1;
                state   <= IDLE;
              end
            end
          end
`endif
          STROBE: begin
            // Frame counts as committed once the strobe has run its full width
            if (cnt == CntW'(StrobeCycles - 1)) begin
              state       <= GAP;
              FrameStrobe <= '0;
              frames_done <= frames_done + 16'd1;
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
          GAP: begin
            state <= IDLE;
          end
          default: begin
            state       <= IDLE;
            FrameStrobe <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_column_loader.sv
// Directed self-checking bench for frame_column_loader; CRC scenarios build when FRAME_CRC_EN is defined.
module tb_frame_column_loader;

  logic         UserCLK;
  logic         resetn;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         abort;
  logic [255:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         busy;
  logic [15:0]  frames_done;
  logic         err_sync;
  logic         err_frame;
  logic         err_crc;

  int tests = 0;
  int fails = 0;

  frame_column_loader dut (
    .UserCLK(UserCLK), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .busy(busy), .frames_done(frames_done), .err_sync(err_sync), .err_frame(err_frame),
    .err_crc(err_crc)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  // Present one word, wait (bounded) for ready, return 1ns after the transfer edge
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge UserCLK); #1;
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout word %h never accepted", w);
    end
    @(posedge UserCLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge UserCLK); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b1; in_data = 32'hFA000001; abort = 1'b0;
    repeat (2) step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", in_ready); end
    tests++; if (FrameData !== 256'h0) begin fails++; $display("FAIL rst_data got %h exp 0", FrameData); end
    tests++; if (FrameStrobe !== 20'h0) begin fails++; $display("FAIL rst_strobe got %h exp 0", FrameStrobe); end
    tests++; if (frames_done !== 16'h0) begin fails++; $display("FAIL rst_count got %h exp 0", frames_done); end
    in_valid = 1'b0;
    @(negedge UserCLK);
    resetn = 1'b1;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_ready got %b exp 1", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rel_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic_frame();
    send_word(32'hFA000003);
    for (int k = 0; k < 8; k++) send_word(32'h1000_0000 + k);
`ifdef FRAME_CRC_EN
    send_word(32'hFA000003);
`endif
    tests++; if (FrameStrobe !== 20'h00008) begin fails++; $display("FAIL basic_strobe1 got %h exp 00008", FrameStrobe); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_strobe got %b exp 0", in_ready); end
    tests++; if (frames_done !== 16'd0) begin fails++; $display("FAIL basic_count_early got %0d exp 0", frames_done); end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (FrameData[k*32 +: 32] !== 32'h1000_0000 + k) begin
        fails++; $display("FAIL basic_row%0d got %h exp %h", k, FrameData[k*32 +: 32], 32'h1000_0000 + k);
      end
    end
    step();
    tests++; if (FrameStrobe !== 20'h00008) begin fails++; $display("FAIL basic_strobe2 got %h exp 00008", FrameStrobe); end
    step();
    tests++; if (FrameStrobe !== 20'h0) begin fails++; $display("FAIL basic_gap got %h exp 0", FrameStrobe); end
    tests++; if (frames_done !== 16'd1) begin fails++; $display("FAIL basic_count got %0d exp 1", frames_done); end
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle got %b exp 0", busy); end
  endtask

  task automatic test_errors();
    send_word(32'hFB000001);
    tests++; if (err_sync !== 1'b1) begin fails++; $display("FAIL sync_pulse got %b exp 1", err_sync); end
    tests++; if (err_frame !== 1'b0) begin fails++; $display("FAIL sync_excl got %b exp 0", err_frame); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sync_idle got %b exp 0", busy); end
    step();
    tests++; if (err_sync !== 1'b0) begin fails++; $display("FAIL sync_width got %b exp 0", err_sync); end
    send_word(32'hFA000014);
    tests++; if (err_frame !== 1'b1) begin fails++; $display("FAIL frame_pulse got %b exp 1", err_frame); end
    tests++; if (err_sync !== 1'b0) begin fails++; $display("FAIL frame_excl got %b exp 0", err_sync); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL frame_idle got %b exp 0", busy); end
    step();
    tests++; if (err_frame !== 1'b0) begin fails++; $display("FAIL frame_width got %b exp 0", err_frame); end
    tests++; if (FrameStrobe !== 20'h0) begin fails++; $display("FAIL frame_strobe got %h exp 0", FrameStrobe); end
  endtask

  task automatic test_backpressure();
    send_word(32'hFA000005);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) step();
      send_word(32'hC0DE_0000 + k);
    end
`ifdef FRAME_CRC_EN
    step();
    send_word(32'hFA000005);
`endif
    in_data  = 32'hDEADBEEF;
    in_valid = 1'b1;
    tests++; if (FrameStrobe !== 20'h00020) begin fails++; $display("FAIL bp_strobe got %h exp 00020", FrameStrobe); end
    for (int c = 0; c < 3; c++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready%0d got %b exp 0", c, in_ready); end
      step();
    end
    in_valid = 1'b0;
    tests++; if (frames_done !== 16'd2) begin fails++; $display("FAIL bp_count got %0d exp 2", frames_done); end
    step();
    tests++; if (err_sync !== 1'b0) begin fails++; $display("FAIL bp_consumed got %b exp 0", err_sync); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle got %b exp 0", busy); end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (FrameData[k*32 +: 32] !== 32'hC0DE_0000 + k) begin
        fails++; $display("FAIL bp_row%0d got %h exp %h", k, FrameData[k*32 +: 32], 32'hC0DE_0000 + k);
      end
    end
  endtask

  task automatic test_abort();
    send_word(32'hFA000002);
    for (int k = 0; k < 3; k++) send_word(32'h7000_0000 + k);
    abort = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL abort_ready got %b exp 0", in_ready); end
    step();
    abort = 1'b0; in_valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
    repeat (4) step();
    tests++; if (FrameStrobe !== 20'h0) begin fails++; $display("FAIL abort_strobe got %h exp 0", FrameStrobe); end
    tests++; if (frames_done !== 16'd2) begin fails++; $display("FAIL abort_count got %0d exp 2", frames_done); end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (FrameData[k*32 +: 32] !== ((k < 3) ? 32'h7000_0000 + k : 32'hC0DE_0000 + k)) begin
        fails++; $display("FAIL abort_row%0d got %h", k, FrameData[k*32 +: 32]);
      end
    end
    send_word(32'hFA000013);
    for (int k = 0; k < 8; k++) send_word(32'h1900_0000 + k);
`ifdef FRAME_CRC_EN
    send_word(32'hFA000013);
`endif
    tests++; if (FrameStrobe !== 20'h80000) begin fails++; $display("FAIL idx19_strobe got %h exp 80000", FrameStrobe); end
    repeat (3) step();
    tests++; if (frames_done !== 16'd3) begin fails++; $display("FAIL idx19_count got %0d exp 3", frames_done); end
  endtask

`ifdef FRAME_CRC_EN
  task automatic test_crc();
    send_word(32'hFA000001);
    for (int k = 0; k < 8; k++) send_word(32'h1 << k);
    send_word(32'hFA0000FE);
    tests++; if (FrameStrobe !== 20'h00002) begin fails++; $display("FAIL crc_ok_strobe got %h exp 00002", FrameStrobe); end
    repeat (3) step();
    tests++; if (frames_done !== 16'd4) begin fails++; $display("FAIL crc_ok_count got %0d exp 4", frames_done); end
    send_word(32'hFA000001);
    for (int k = 0; k < 8; k++) send_word(32'h1 << k);
    send_word(32'hFA0000FF);
    tests++; if (err_crc !== 1'b1) begin fails++; $display("FAIL crc_bad_pulse got %b exp 1", err_crc); end
    tests++; if (FrameStrobe !== 20'h0) begin fails++; $display("FAIL crc_bad_strobe got %h exp 0", FrameStrobe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL crc_bad_idle got %b exp 0", busy); end
    repeat (3) step();
    tests++; if (err_crc !== 1'b0) begin fails++; $display("FAIL crc_bad_width got %b exp 0", err_crc); end
    tests++; if (frames_done !== 16'd4) begin fails++; $display("FAIL crc_bad_count got %0d exp 4", frames_done); end
    tests++; if (FrameData[7*32 +: 32] !== 32'h80) begin fails++; $display("FAIL crc_bad_data got %h exp 80", FrameData[7*32 +: 32]); end
  endtask
`endif

  task automatic test_reset_mid_strobe();
    send_word(32'hFA000000);
    for (int k = 0; k < 8; k++) send_word(32'h5000_0000 + k);
`ifdef FRAME_CRC_EN
    send_word(32'hFA000000);
`endif
    tests++; if (FrameStrobe !== 20'h00001) begin fails++; $display("FAIL rms_strobe got %h exp 00001", FrameStrobe); end
    #1 resetn = 1'b0;
    #1;
    tests++; if (FrameStrobe !== 20'h0) begin fails++; $display("FAIL rms_drop got %h exp 0", FrameStrobe); end
    tests++; if (frames_done !== 16'd0) begin fails++; $display("FAIL rms_count got %0d exp 0", frames_done); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rms_ready got %b exp 0", in_ready); end
    @(negedge UserCLK);
    resetn = 1'b1;
    repeat (3) step();
    tests++; if (frames_done !== 16'd0) begin fails++; $display("FAIL rms_after got %0d exp 0", frames_done); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_errors();
    test_backpressure();
    test_abort();
`ifdef FRAME_CRC_EN
    test_crc();
`endif
    test_reset_mid_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_column_loader.md
Name: frame_column_loader

Overview:
- Configuration controller for one fabric column (e.g. an S_term_IHP_SRAM column).
- Accepts a stream of 32-bit configuration words over a valid/ready handshake and assembles one frame's worth of FrameData for all rows of the column.
- Then pulses the one-hot FrameStrobe line for the addressed frame so every tile in the column latches its bits.
- Sits between the bitstream source (UART/SPI config port) and the column's FrameData/FrameStrobe inputs.

Parameters:
- NumRows, 8, tiles in the column; FrameData width = NumRows*FrameBitsPerRow.
- FrameBitsPerRow, 32, bits per row per frame; fixed equal to the input word width.
- MaxFramesPerCol, 20, number of frame strobe lines.
- StrobeCycles, 2, cycles FrameStrobe stays asserted (>=1).

Ports:
- UserCLK  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- in_data  input  FrameBitsPerRow  configuration word.
- in_valid  input  1  word valid.
- in_ready  output  1  loader accepts word this cycle.
- abort  input  1  synchronous abort of the frame in progress.
- FrameData  output  NumRows*FrameBitsPerRow  assembled frame data to the column.
- FrameStrobe  output  MaxFramesPerCol  one-hot frame write strobe.
- busy  output  1  high whenever state != IDLE.
- frames_done  output  16  count of committed frames, wraps 16'hFFFF->0.
- err_sync  output  1  one-cycle pulse: bad header sync.
- err_frame  output  1  one-cycle pulse: frame index out of range.
- err_crc  output  1  one-cycle pulse: checksum mismatch (FRAME_CRC_EN only).

Behaviour:
- Clock and reset: one clock, UserCLK. resetn is asynchronous and active-low.
- Reset values: state IDLE; FrameData 0; FrameStrobe 0; frames_done 0; all err_* 0; in_ready 0 while resetn low.
- Transfer rule: a word transfers when in_valid && in_ready on a rising edge. in_ready = 1 in IDLE and DATA (and CRC); 0 in STROBE and GAP.
- Header word: in_data[31:24] = 8'hFA (sync); in_data[7:0] = frame index idx; other bits ignored.
- IDLE, header transfers:
  - sync != 8'hFA -> err_sync pulse next cycle; stay IDLE.
  - idx >= MaxFramesPerCol -> err_frame pulse next cycle; stay IDLE.
  - Otherwise latch idx, clear row counter, go to DATA.
- DATA:
  - k-th data word (k = 0..NumRows-1) is written to FrameData[k*FrameBitsPerRow +: FrameBitsPerRow] on its transfer edge.
  - The last word (k = NumRows-1) moves to STROBE, or to CRC when FRAME_CRC_EN is defined.
  - Rows not yet written keep their previous-frame values.
- STROBE: FrameStrobe = 1 << idx for exactly StrobeCycles cycles, starting the cycle after the last data/CRC transfer. FrameData is stable throughout. Then go to GAP.
- GAP: one cycle with FrameStrobe = 0. frames_done increments on this cycle. Return to IDLE.
  - Minimum header-to-header spacing = NumRows + StrobeCycles + 2 cycles.
- abort (sampled every cycle, priority over all transfers):
  - Next state IDLE; FrameStrobe forced to 0 on the next edge.
  - frames_done unchanged; FrameData holds its current value.
  - A word presented in the same cycle as abort is not accepted: in_ready is forced low when abort = 1.
- Async reset mid-STROBE: FrameStrobe drops immediately; no frame count.
- Error pulses are mutually exclusive and registered (one cycle wide).

Optional Feature:
- Macro: FRAME_CRC_EN.
- Defined:
  - After the NumRows data words, state CRC accepts one trailer word.
  - Expected value = XOR of the header word and all NumRows data words.
  - Match -> STROBE.
  - Mismatch -> err_crc pulse, no strobe, frames_done unchanged, back to IDLE; FrameData keeps the written data.
- Not defined: no CRC state, no trailer word; err_crc tied 0.

Test Plan:
- Reset with in_valid=1 -> in_ready=0, FrameData=0, FrameStrobe=0. Release -> in_ready=1, busy=0.
- Header 32'hFA000003, then 8 words 32'h1000_0000+k -> FrameData row k = 32'h1000_000k; FrameStrobe=20'h00008 for exactly 2 cycles after the last word; frames_done 0->1.
- Header 32'hFB000001 -> err_sync pulses 1 cycle, state IDLE. Header 32'hFA000014 (idx 20) -> err_frame pulse, FrameStrobe stays 0.
- Backpressure: hold in_valid low for random gaps between data words; assert in_valid during STROBE -> in_ready=0, no word consumed, final FrameData correct.
- abort after 3 data words -> busy drops next cycle, no strobe, frames_done unchanged. Next complete frame to idx 19 -> FrameStrobe=20'h80000.
- FRAME_CRC_EN: correct XOR trailer -> strobe and count. Trailer XOR'd with 1 -> err_crc, no strobe.
